// File: rtl/ysyx_220066_defs.sv
// Shared definitions for the memory arbiter: FSM state encoding and MemOp codes.
package ysyx_220066_defs;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        IF_REQ  = 3'd1,
        IF_WAIT = 3'd2,
        D_REQ   = 3'd3,
        D_WAIT  = 3'd4
    } arb_state_e;

    typedef enum logic [2:0] {
        MOP_LB  = 3'd0,
        MOP_LH  = 3'd1,
        MOP_LW  = 3'd2,
        MOP_LD  = 3'd3,
        MOP_LBU = 3'd4,
        MOP_LHU = 3'd5,
        MOP_LWU = 3'd6
    } mem_op_e;

    // Instruction fetches are always an unsigned 32-bit word read.
    localparam logic [2:0] IF_FETCH_OP = MOP_LWU;

endpackage

// File: rtl/ysyx_220066_arb_timer.sv
// Transaction watchdog: counts cycles while enabled, flags expiry on the
// TIMEOUT_CYC-th enabled cycle so the abort response lands one cycle later.
module ysyx_220066_arb_timer #(
    parameter int TIMEOUT_CYC = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != LAST)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = en && (cnt_q == LAST);

endmodule

// File: rtl/ysyx_220066_mem_arbiter.sv
// Two-master (fetch/data) arbiter onto one memory port, one transaction in flight.
// Define YSYX_220066_ARB_RR_EN for round-robin; default is data priority with IF starvation limit.
module ysyx_220066_mem_arbiter
    import ysyx_220066_defs::*;
#(
    parameter int TIMEOUT_CYC   = 256,
    parameter int IF_STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        if_req,
    input  logic [63:0] if_addr,
    output logic        if_ready,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    output logic        if_err,

    input  logic        d_req,
    input  logic        d_wen,
    input  logic [2:0]  d_op,
    input  logic [63:0] d_addr,
    input  logic [63:0] d_wdata,
    output logic        d_ready,
    output logic        d_rvalid,
    output logic [63:0] d_rdata,
    output logic        d_err,

    output logic        mem_req,
    output logic        mem_wen,
    output logic [2:0]  mem_op,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [63:0] mem_rdata,
    input  logic        mem_err
);

    arb_state_e  state_q, state_d;

    logic        wen_q, wen_d;
    logic [2:0]  op_q, op_d;
    logic [63:0] addr_q, addr_d;
    logic [63:0] wdata_q, wdata_d;
    logic        sel_hi_q, sel_hi_d;

    logic        if_rvalid_q, if_rvalid_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic        if_err_q, if_err_d;
    logic        d_rvalid_q, d_rvalid_d;
    logic [63:0] d_rdata_q, d_rdata_d;
    logic        d_err_q, d_err_d;

    logic        pick_if;
    logic        tmr_clr;
    logic        tmr_expired;

`ifdef YSYX_220066_ARB_RR_EN
    logic        last_if_q, last_if_d;
    assign pick_if = if_req && (!d_req || !last_if_q);
`else
    localparam int SW = $clog2(IF_STARVE_MAX + 2);
    logic [SW-1:0] starve_q, starve_d;
    assign pick_if = if_req && (!d_req || (starve_q >= SW'(IF_STARVE_MAX)));
`endif

    assign tmr_clr = (state_q == IDLE);

    ysyx_220066_arb_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (tmr_clr),
        .en      (!tmr_clr),
        .expired (tmr_expired)
    );

    always_comb begin
        state_d     = state_q;
        wen_d       = wen_q;
        op_d        = op_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        sel_hi_d    = sel_hi_q;
        if_rvalid_d = 1'b0;
        if_rdata_d  = if_rdata_q;
        if_err_d    = if_err_q;
        d_rvalid_d  = 1'b0;
        d_rdata_d   = d_rdata_q;
        d_err_d     = d_err_q;
        if_ready    = 1'b0;
        d_ready     = 1'b0;
        mem_req     = 1'b0;
`ifdef YSYX_220066_ARB_RR_EN
        last_if_d   = last_if_q;
`else
        starve_d    = starve_q;
`endif
        case (state_q)
            IDLE: begin
                if (pick_if) begin
                    state_d  = IF_REQ;
                    wen_d    = 1'b0;
                    op_d     = IF_FETCH_OP;
                    addr_d   = if_addr;
                    wdata_d  = '0;
                    sel_hi_d = if_addr[2];
                end else if (d_req) begin
                    state_d  = D_REQ;
                    wen_d    = d_wen;
                    op_d     = d_op;
                    addr_d   = d_addr;
                    wdata_d  = d_wdata;
                    sel_hi_d = 1'b0;
                end
`ifdef YSYX_220066_ARB_RR_EN
                if (pick_if) begin
                    last_if_d = 1'b1;
                end else if (d_req) begin
                    last_if_d = 1'b0;
                end
`else
                // Only data grants that bypass a waiting fetch count toward starvation.
                if (pick_if || !if_req) begin
                    starve_d = '0;
                end else if (d_req) begin
                    starve_d = starve_q + 1'b1;
                end
`endif
            end
            IF_REQ: begin
                mem_req = 1'b1;
                if (mem_gnt) begin
                    if_ready = 1'b1;
                    state_d  = IF_WAIT;
                end else if (tmr_expired) begin
                    if_rvalid_d = 1'b1;
                    if_rdata_d  = '0;
                    if_err_d    = 1'b1;
                    state_d     = IDLE;
                end
            end
            IF_WAIT: begin
                if (mem_rvalid) begin
                    if_rvalid_d = 1'b1;
                    if_rdata_d  = sel_hi_q ? mem_rdata[63:32] : mem_rdata[31:0];
                    if_err_d    = mem_err;
                    state_d     = IDLE;
                end else if (tmr_expired) begin
                    if_rvalid_d = 1'b1;
                    if_rdata_d  = '0;
                    if_err_d    = 1'b1;
                    state_d     = IDLE;
                end
            end
            D_REQ: begin
                mem_req = 1'b1;
                if (mem_gnt) begin
                    d_ready = 1'b1;
                    state_d = D_WAIT;
                end else if (tmr_expired) begin
                    d_rvalid_d = 1'b1;
                    d_rdata_d  = '0;
                    d_err_d    = 1'b1;
                    state_d    = IDLE;
                end
            end
            D_WAIT: begin
                if (mem_rvalid) begin
                    d_rvalid_d = 1'b1;
                    d_rdata_d  = mem_rdata;
                    d_err_d    = mem_err;
                    state_d    = IDLE;
                end else if (tmr_expired) begin
                    d_rvalid_d = 1'b1;
                    d_rdata_d  = '0;
                    d_err_d    = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            wen_q       <= 1'b0;
            op_q        <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            sel_hi_q    <= 1'b0;
            if_rvalid_q <= 1'b0;
            if_rdata_q  <= '0;
            if_err_q    <= 1'b0;
            d_rvalid_q  <= 1'b0;
            d_rdata_q   <= '0;
            d_err_q     <= 1'b0;
`ifdef YSYX_220066_ARB_RR_EN
            last_if_q   <= 1'b1;
`else
            starve_q    <= '0;
`endif
        end else begin
            state_q     <= state_d;
            wen_q       <= wen_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            sel_hi_q    <= sel_hi_d;
            if_rvalid_q <= if_rvalid_d;
            if_rdata_q  <= if_rdata_d;
            if_err_q    <= if_err_d;
            d_rvalid_q  <= d_rvalid_d;
            d_rdata_q   <= d_rdata_d;
            d_err_q     <= d_err_d;
`ifdef YSYX_220066_ARB_RR_EN
            last_if_q   <= last_if_d;
`else
            starve_q    <= starve_d;
`endif
        end
    end

    assign mem_wen   = wen_q;
    assign mem_op    = op_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    assign if_rvalid = if_rvalid_q;
    assign if_rdata  = if_rdata_q;
    assign if_err    = if_err_q;
    assign d_rvalid  = d_rvalid_q;
    assign d_rdata   = d_rdata_q;
    assign d_err     = d_err_q;

endmodule

// File: tb/tb_ysyx_220066_mem_arbiter.sv
// Scoreboard bench for ysyx_220066_mem_arbiter with a small memory responder model.
module tb_ysyx_220066_mem_arbiter;
    import ysyx_220066_defs::*;

    logic        clk, rst;
    logic        if_req;
    logic [63:0] if_addr;
    logic        if_ready, if_rvalid, if_err;
    logic [31:0] if_rdata;
    logic        d_req, d_wen;
    logic [2:0]  d_op;
    logic [63:0] d_addr, d_wdata;
    logic        d_ready, d_rvalid, d_err;
    logic [63:0] d_rdata;
    logic        mem_req, mem_wen;
    logic [2:0]  mem_op;
    logic [63:0] mem_addr, mem_wdata;
    logic        mem_gnt, mem_rvalid, mem_err;
    logic [63:0] mem_rdata;

    ysyx_220066_mem_arbiter #(
        .TIMEOUT_CYC   (16),
        .IF_STARVE_MAX (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_ready   (if_ready),
        .if_rvalid  (if_rvalid),
        .if_rdata   (if_rdata),
        .if_err     (if_err),
        .d_req      (d_req),
        .d_wen      (d_wen),
        .d_op       (d_op),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_ready    (d_ready),
        .d_rvalid   (d_rvalid),
        .d_rdata    (d_rdata),
        .d_err      (d_err),
        .mem_req    (mem_req),
        .mem_wen    (mem_wen),
        .mem_op     (mem_op),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .mem_err    (mem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          is_if;
        logic [63:0] data;
        bit          err;
        bit          chk_data;
    } sb_entry_t;

    sb_entry_t sb[$];
    bit        grant_q[$];
    int        checks   = 0;
    int        failures = 0;
    int        d_ready_cnt  = 0;
    int        d_rvalid_cnt = 0;

    // Memory responder knobs
    int          gnt_delay = 0;
    bit          gnt_never = 0;
    int          gnt_wait  = 0;
    logic [63:0] rsp_data  = '0;
    logic [63:0] rsp_inc   = '0;
    bit          rsp_err   = 0;
    bit          rsp_pend  = 0;
    bit          stray_rsp = 0;
    logic [63:0] pend_data = '0;
    bit          pend_err  = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        mem_rvalid = 1'b0;
        mem_err    = 1'b0;
        mem_rdata  = '0;
        if (rsp_pend || stray_rsp) begin
            mem_rvalid = 1'b1;
            mem_rdata  = pend_data;
            mem_err    = pend_err;
            rsp_pend   = 0;
            stray_rsp  = 0;
        end
        mem_gnt = 1'b0;
        if (mem_req && !gnt_never) begin
            if (gnt_wait >= gnt_delay) begin
                mem_gnt   = 1'b1;
                gnt_wait  = 0;
                rsp_pend  = 1;
                pend_data = rsp_data;
                pend_err  = rsp_err;
                rsp_data  = rsp_data + rsp_inc;
            end else begin
                gnt_wait++;
            end
        end else begin
            gnt_wait = 0;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            if (if_ready || d_ready || if_rvalid || d_rvalid)
                check_eq("strobe_excl", 64'($countones({if_ready, d_ready, if_rvalid, d_rvalid})), 64'd1);
            if (if_ready) begin
                grant_q.push_back(1'b1);
                sb.push_back('{1'b1, if_addr[2] ? {32'h0, pend_data[63:32]} : {32'h0, pend_data[31:0]},
                               pend_err, 1'b1});
            end
            if (d_ready) begin
                grant_q.push_back(1'b0);
                d_ready_cnt++;
                sb.push_back('{1'b0, pend_data, pend_err, !d_wen});
            end
            if (if_rvalid || d_rvalid) begin
                if (d_rvalid) d_rvalid_cnt++;
                check_eq("sb_nonempty", 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0) begin
                    sb_entry_t e;
                    e = sb.pop_front();
                    check_eq("rsp_port", 64'(if_rvalid), 64'(e.is_if));
                    if (e.chk_data)
                        check_eq("rsp_data", if_rvalid ? {32'h0, if_rdata} : d_rdata, e.data);
                    check_eq("rsp_err", 64'(if_rvalid ? if_err : d_err), 64'(e.err));
                end
            end
        end
    end

    task automatic run_wait(input bit is_if, output int lat);
        lat = -1;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (is_if ? if_ready : d_ready) begin
                if (is_if) if_req = 1'b0; else d_req = 1'b0;
            end
            if (is_if ? if_rvalid : d_rvalid) begin
                if (is_if) if_req = 1'b0; else d_req = 1'b0;
                lat = c;
                break;
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_strobes"}, 64'({if_ready, if_rvalid, if_err, d_ready, d_rvalid, d_err, mem_req, mem_wen}), 64'd0);
        check_eq({tag, "_if_rdata"}, 64'(if_rdata), 64'd0);
        check_eq({tag, "_d_rdata"}, d_rdata, 64'd0);
        check_eq({tag, "_mem_addr"}, mem_addr, 64'd0);
        check_eq({tag, "_mem_wdata"}, mem_wdata, 64'd0);
        check_eq({tag, "_mem_op"}, 64'(mem_op), 64'd0);
    endtask

    initial begin
        int lat;
        int cnt0;
        bit found;
        rst = 1'b0; if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_wen = 1'b0; d_op = '0; d_addr = '0; d_wdata = '0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; mem_err = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Fetch from upper word, minimum latency
        rsp_data = 64'h11112222_33334444;
        @(posedge clk); #1 if_req = 1'b1; if_addr = 64'h80000004;
        run_wait(1'b1, lat);
        check_eq("if_hi_lat", 64'(lat), 64'd3);
        check_eq("if_hi_rdata", 64'(if_rdata), 64'h11112222);
        check_eq("if_hi_err", 64'(if_err), 64'd0);
        check_eq("if_mem_op", 64'(mem_op), 64'(MOP_LWU));
        repeat (2) @(negedge clk);

        // Fetch from lower word
        rsp_data = 64'hAAAABBBB_CCCCDDDD;
        @(posedge clk); #1 if_req = 1'b1; if_addr = 64'h80000010;
        run_wait(1'b1, lat);
        check_eq("if_lo_lat", 64'(lat), 64'd3);
        check_eq("if_lo_rdata", 64'(if_rdata), 64'hCCCCDDDD);
        repeat (2) @(negedge clk);

        // Data read
        rsp_data = 64'hDEADBEEF_CAFEF00D;
        @(posedge clk); #1 d_req = 1'b1; d_wen = 1'b0; d_op = MOP_LD; d_addr = 64'h80001000;
        run_wait(1'b0, lat);
        check_eq("d_rd_lat", 64'(lat), 64'd3);
        check_eq("d_rd_mem_addr", mem_addr, 64'h80001000);
        check_eq("d_rd_mem_op", 64'(mem_op), 64'(MOP_LD));
        repeat (2) @(negedge clk);

        // Data write, late grant, error response
        gnt_delay = 5; rsp_err = 1; d_ready_cnt = 0; d_rvalid_cnt = 0;
        @(posedge clk); #1 d_req = 1'b1; d_wen = 1'b1; d_op = MOP_LW;
        d_addr = 64'h80002008; d_wdata = 64'h01234567_89ABCDEF;
        run_wait(1'b0, lat);
        repeat (5) @(negedge clk);
        check_eq("wr_lat", 64'(lat), 64'd8);
        check_eq("wr_ready_cnt", 64'(d_ready_cnt), 64'd1);
        check_eq("wr_rvalid_cnt", 64'(d_rvalid_cnt), 64'd1);
        check_eq("wr_mem_wen", 64'(mem_wen), 64'd1);
        check_eq("wr_mem_wdata", mem_wdata, 64'h01234567_89ABCDEF);
        gnt_delay = 0; rsp_err = 0; d_wen = 1'b0;

        // Grant never arrives: abort after 16 cycles in D_REQ, stray response dropped
        gnt_never = 1; d_rvalid_cnt = 0;
        sb.push_back('{1'b0, 64'd0, 1'b1, 1'b1});
        @(posedge clk); #1 d_req = 1'b1; d_op = MOP_LD; d_addr = 64'h80003000;
        run_wait(1'b0, lat);
        check_eq("to_lat", 64'(lat), 64'd17);
        check_eq("to_mem_req", 64'(mem_req), 64'd0);
        stray_rsp = 1; pend_data = 64'h5555; pend_err = 0;
        gnt_never = 0;
        repeat (5) @(negedge clk);
        check_eq("to_rvalid_cnt", 64'(d_rvalid_cnt), 64'd1);

        // Reset asserted in D_WAIT
        rsp_data = 64'h77778888_9999AAAA;
        @(posedge clk); #1 d_req = 1'b1; d_op = MOP_LD; d_addr = 64'h80004000;
        found = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (d_ready) begin
                d_req = 1'b0;
                found = 1;
                break;
            end
        end
        check_eq("rst_t_ready", 64'(found), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_all_zero("rst_mid");
        sb.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        cnt0 = d_rvalid_cnt;
        repeat (8) @(negedge clk);
        check_eq("rst_no_rvalid", 64'(d_rvalid_cnt), 64'(cnt0));

        // Both masters held continuously: grant order straight after reset
        grant_q.delete();
        rsp_data = 64'h10000000_20000000; rsp_inc = 64'h00000001_00000001;
        @(posedge clk); #1 if_req = 1'b1; if_addr = 64'h80000000;
        d_req = 1'b1; d_op = MOP_LD; d_addr = 64'h80005000;
        found = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (grant_q.size() >= 10) begin
                if_req = 1'b0; d_req = 1'b0;
                found = 1;
                break;
            end
        end
        check_eq("ord_done", 64'(found), 64'd1);
        repeat (6) @(negedge clk);
        check_eq("ord_count", 64'(grant_q.size()), 64'd10);
        for (int k = 0; k < 10 && k < grant_q.size(); k++) begin
            bit exp_if;
`ifdef YSYX_220066_ARB_RR_EN
            exp_if = (k % 2) == 1;
`else
            exp_if = (k % 5) == 4;
`endif
            check_eq($sformatf("ord_%0d", k), 64'(grant_q[k]), 64'(exp_if));
        end

        check_eq("sb_drained", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "bench time limit");
    end

endmodule

// File: doc/ysyx_220066_mem_arbiter.md
YSYX_220066_MEM_ARBITER -- requirements
Module: ysyx_220066_mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 256: cycles a transaction may wait for mem_gnt plus mem_rvalid before it is aborted.
REQ-002 SHALL have parameter IF_STARVE_MAX, default 4: maximum consecutive data grants allowed while if_req is pending (fixed-priority build only).
REQ-003 SHALL have port clk, input, 1: single clock; all logic on posedge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have ports if_req (in, 1) and if_addr (in, 64): instruction fetch request; read-only, 32-bit word.
REQ-006 SHALL have ports if_ready (out, 1), if_rvalid (out, 1), if_rdata (out, 32) and if_err (out, 1): fetch accept pulse and fetch response.
REQ-007 SHALL have ports d_req (in, 1), d_wen (in, 1), d_op (in, 3), d_addr (in, 64) and d_wdata (in, 64): data request; d_op carries the MemOp encoding.
REQ-008 SHALL have ports d_ready (out, 1), d_rvalid (out, 1), d_rdata (out, 64) and d_err (out, 1): data accept pulse and data response.
REQ-009 SHALL have ports mem_req (out, 1), mem_wen (out, 1), mem_op (out, 3), mem_addr (out, 64) and mem_wdata (out, 64): shared downstream request.
REQ-010 SHALL have ports mem_gnt (in, 1), mem_rvalid (in, 1), mem_rdata (in, 64) and mem_err (in, 1): downstream accept and response.

Function
REQ-011 SHALL implement FSM states IDLE, IF_REQ, IF_WAIT, D_REQ and D_WAIT, with one transaction outstanding at most.
REQ-012 SHALL, in IDLE, sample if_req and d_req, pick a winner per REQ-013/REQ-023, latch the winner's fields, and move to IF_REQ or D_REQ next cycle.
REQ-013 SHALL, when both requests are present, grant data unless the starvation counter has reached IF_STARVE_MAX; the counter counts data grants with if_req pending and clears on any IF grant or on an idle if_req.
REQ-014 SHALL, in *_REQ, hold mem_req=1 with stable latched fields until mem_gnt; that cycle it pulses the winner's if_ready/d_ready for 1 cycle and moves to *_WAIT.
REQ-015 SHALL, in *_WAIT, on mem_rvalid, register the response and pulse if_rvalid/d_rvalid exactly 1 cycle later, with rdata and err valid in the same cycle; the FSM returns to IDLE.
REQ-016 SHALL drive if_rdata = mem_rdata[63:32] when latched if_addr[2]=1, else mem_rdata[31:0].
REQ-017 SHALL require a write to complete via mem_rvalid; d_rdata is don't-care for writes and d_err is valid.
REQ-018 SHALL give a minimum latency of 3 cycles from req sampled in IDLE to rvalid (gnt in the first REQ cycle, rvalid in the first WAIT cycle).
REQ-019 SHALL ignore mem_rvalid while in IDLE or *_REQ; such stray responses SHALL be dropped.
REQ-020 SHALL abort a transaction when the timer reaches TIMEOUT_CYC in *_REQ or *_WAIT: rvalid pulses with err=1 and rdata=0, mem_req drops, and the FSM returns to IDLE.
REQ-021 SHALL keep if_ready, d_ready, if_rvalid and d_rvalid at 0 outside their pulse cycles; the IF and data strobes SHALL never be high in the same cycle.

Reset
REQ-022 SHALL, while rst=0 (asynchronous, at any time including mid-transaction), force state IDLE, all outputs 0, the starvation counter to 0 and the timer to 0; an in-flight transaction is abandoned with no response.

Configuration
REQ-023 With YSYX_220066_ARB_RR_EN defined, the block SHALL use round-robin on simultaneous requests, granting the requester not granted last (data first after reset), and SHALL ignore IF_STARVE_MAX.
REQ-024 With YSYX_220066_ARB_RR_EN undefined, the block SHALL use fixed data priority with starvation limit per REQ-013.

Structure
REQ-025 SHALL take the FSM state enum and the MemOp encodings from shared package ysyx_220066_defs.
REQ-026 SHALL place the timeout counter in sub-module ysyx_220066_arb_timer (clear/enable in, expired out).

Verification
REQ-027 Bench: IF-only read, if_addr=0x80000004, mem_gnt same cycle, mem_rdata=0x11112222_33334444 next cycle -> if_rvalid in cycle 3 with if_rdata=0x11112222 and if_err=0.
REQ-028 Bench: if_req and d_req held continuously in fixed-priority build -> grant order D,D,D,D,IF,D,D,D,D,IF.
REQ-029 Bench: same stimulus with YSYX_220066_ARB_RR_EN defined -> grant order D,IF,D,IF.
REQ-030 Bench: data write, mem_gnt delayed 5 cycles, then mem_rvalid with mem_err=1 -> single d_ready pulse at gnt, then d_rvalid=1 and d_err=1 exactly once.
REQ-031 Bench: mem_gnt never asserted with TIMEOUT_CYC=16 -> d_rvalid with d_err=1 16 cycles after entering D_REQ; a mem_rvalid on the next cycle is dropped.
REQ-032 Bench: rst pulled low during D_WAIT -> all outputs 0 immediately, with no d_rvalid after release.
